if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low; asserted (0) forces reset state immediately.
REQ-004 pcWrite  in  1  PC update enable from hazard unit.
REQ-005 IFIDWrite  in  1  IF/ID register write enable from hazard unit.
REQ-006 ifNop  in  1  flush/redirect request from hazard unit (taken beq/bne or jump).
REQ-007 redirectPC  in  32  target PC, valid when ifNop=1.
REQ-008 imemReq  out  1  instruction memory request.
REQ-009 imemAddr  out  32  fetch address; bits[1:0] always 0.
REQ-010 imemRdata  in  32  instruction word, valid in the cycle imemReady=1.
REQ-011 imemReady  in  1  memory response strobe; completes the current request.
REQ-012 IFIDInst  out  32  registered instruction to ID.
REQ-013 IFIDPC4  out  32  registered PC+4 of IFIDInst.
REQ-014 IFIDValid  out  1  1 = IFIDInst is a real instruction; 0 = bubble (IFIDInst=0).
REQ-015 fetchStall  out  1  combinational; 1 while the fetch is waiting on memory.
REQ-016 stallCnt  out  16  saturating count of cycles with fetchStall=1.

Function
REQ-017 advance = IFIDWrite & pcWrite; when advance=0, PC, IF/ID outputs and pendPC are held, and ifNop/redirectPC are ignored in that cycle.
REQ-018 State machine states: FETCH, HOLD, DROP; no other encodings reachable.
REQ-019 FETCH: imemReq=1, imemAddr=PC.
REQ-020 FETCH, imemReady=1, advance=1, ifNop=0: IF/ID <= {imemRdata, PC+4, valid=1}; PC <= PC+4; stay FETCH.
REQ-021 FETCH, imemReady=1, advance=1, ifNop=1: response discarded; IF/ID <= bubble; PC <= {redirectPC[31:2],2'b00}; stay FETCH.
REQ-022 FETCH, imemReady=1, advance=0: holdInst <= imemRdata, holdPC4 <= PC+4; go HOLD.
REQ-023 FETCH, imemReady=0, advance=1, ifNop=0: IF/ID <= bubble; stay FETCH.
REQ-024 FETCH, imemReady=0, advance=1, ifNop=1: IF/ID <= bubble; pendPC <= {redirectPC[31:2],2'b00}; go DROP.
REQ-025 imemAddr shall not change while imemReq=1 and imemReady=0.
REQ-026 HOLD: imemReq=0; on advance=1 with ifNop=0: IF/ID <= {holdInst, holdPC4, 1}, PC <= PC+4, go FETCH; with ifNop=1: IF/ID <= bubble, PC <= redirect target, hold data discarded, go FETCH.
REQ-027 DROP: imemReq=1, imemAddr=PC (old address); advance=1 writes bubble to IF/ID; advance=1 & ifNop=1 overwrites pendPC.
REQ-028 DROP, imemReady=1: response discarded; PC <= pendPC (or the same-cycle new redirect target if REQ-027 overwrite applies); go FETCH.
REQ-029 fetchStall = (state==FETCH & ~imemReady) | (state==DROP).
REQ-030 stallCnt increments by 1 each cycle fetchStall=1, saturates at 16'hFFFF, never wraps.
REQ-031 PC+4 is computed modulo 2^32; PC=32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-032 A bubble is exactly IFIDInst=0, IFIDValid=0, IFIDPC4 unchanged.

Reset
REQ-033 While rst=0: PC=RESET_PC, state=FETCH, IFIDInst=0, IFIDPC4=0, IFIDValid=0, holdInst=0, holdPC4=0, pendPC=0, stallCnt=0.
REQ-034 First request after rst deasserts is imemReq=1, imemAddr=RESET_PC in the first cycle.
REQ-035 rst asserted in HOLD or DROP abandons the buffered/outstanding fetch; any imemReady arriving after reset release without a new request is ignored only if it is the response to the RESET_PC request (memory shall be reset with the block).

Verification
REQ-036 Zero-wait stream: imemReady=1 constantly, advance=1, ifNop=0 from RESET_PC=0 -> IFIDPC4 = 4,8,12,... one per cycle, IFIDValid=1, stallCnt=0.
REQ-037 Wait states: imemReady low 3 cycles for PC=8 -> 3 bubbles, fetchStall=1 for 3 cycles, imemAddr stable at 8, stallCnt=3, then IFIDPC4=12 valid.
REQ-038 Stall during response: imemReady=1, advance=0 for 2 cycles at PC=16 -> HOLD, imemReq=0, IF/ID unchanged; advance=1 -> IFIDInst=captured word, IFIDPC4=20, next imemAddr=20.
REQ-039 Redirect in flight: imemReady=0 at PC=24, ifNop=1, redirectPC=32'h100 -> DROP, imemAddr stays 24; on imemReady=1 the word is dropped, next imemAddr=32'h100, no valid IF/ID for PC 24.
REQ-040 Stall priority: advance=0 with ifNop=1, redirectPC=32'h200 -> PC and IF/ID unchanged, no redirect taken; rst pulse low mid-DROP -> all outputs at REQ-033 values asynchronously.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with hazard-aware PC control and IF/ID register.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   pcWrite    in   PC update enable from hazard unit
//   IFIDWrite  in   IF/ID write enable from hazard unit
//   ifNop      in   flush/redirect request (taken branch or jump)
//   redirectPC in   redirect target, valid while ifNop=1
//   imemReq    out  instruction memory request
//   imemAddr   out  word-aligned fetch address
//   imemRdata  in   instruction word, valid with imemReady
//   imemReady  in   memory response strobe
//   IFIDInst   out  registered instruction to ID (0 for a bubble)
//   IFIDPC4    out  registered PC+4 of IFIDInst
//   IFIDValid  out  1 = real instruction, 0 = bubble
//   fetchStall out  1 while fetch is waiting on memory
//   stallCnt   out  saturating count of stalled cycles
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcWrite,
    input  logic        IFIDWrite,
    input  logic        ifNop,
    input  logic [31:0] redirectPC,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemRdata,
    input  logic        imemReady,
    output logic [31:0] IFIDInst,
    output logic [31:0] IFIDPC4,
    output logic        IFIDValid,
    output logic        fetchStall,
    output logic [15:0] stallCnt
);

    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

    state_t      state, state_d;
    logic [31:0] pc, pc_d;
    logic [31:0] hold_inst, hold_inst_d;
    logic [31:0] hold_pc4, hold_pc4_d;
    logic [31:0] pend_pc, pend_pc_d;
    logic [31:0] inst_d, pc4_d;
    logic        valid_d;
    logic        advance;
    logic [31:0] pc4;
    logic [31:0] redir;

    assign advance    = IFIDWrite & pcWrite;
    assign pc4        = pc + 32'd4;
    assign redir      = redirectPC & 32'hFFFF_FFFC;
    assign imemAddr   = pc & 32'hFFFF_FFFC;
    assign imemReq    = (state != HOLD);
    assign fetchStall = (state == FETCH && !imemReady) || (state == DROP);

    always_comb begin
        state_d     = state;
        pc_d        = pc;
        inst_d      = IFIDInst;
        pc4_d       = IFIDPC4;
        valid_d     = IFIDValid;
        hold_inst_d = hold_inst;
        hold_pc4_d  = hold_pc4;
        pend_pc_d   = pend_pc;
        case (state)
            FETCH: begin
                if (imemReady) begin
                    if (advance) begin
                        if (ifNop) begin
                            inst_d  = '0;
                            valid_d = 1'b0;
                            pc_d    = redir;
                        end else begin
                            inst_d  = imemRdata;
                            pc4_d   = pc4;
                            valid_d = 1'b1;
                            pc_d    = pc4;
                        end
                    end else begin
                        // Park the completed response until the pipeline can take it.
                        hold_inst_d = imemRdata;
                        hold_pc4_d  = pc4;
                        state_d     = HOLD;
                    end
                end else if (advance) begin
                    inst_d  = '0;
                    valid_d = 1'b0;
                    if (ifNop) begin
                        // The request in flight cannot be cancelled; remember the target.
                        pend_pc_d = redir;
                        state_d   = DROP;
                    end
                end
            end
            HOLD: begin
                if (advance) begin
                    state_d = FETCH;
                    if (ifNop) begin
                        inst_d  = '0;
                        valid_d = 1'b0;
                        pc_d    = redir;
                    end else begin
                        inst_d  = hold_inst;
                        pc4_d   = hold_pc4;
                        valid_d = 1'b1;
                        pc_d    = pc4;
                    end
                end
            end
            DROP: begin
                if (advance) begin
                    inst_d  = '0;
                    valid_d = 1'b0;
                    if (ifNop)
                        pend_pc_d = redir;
                end
                // The stale response retires the outstanding request; the newest redirect wins.
                if (imemReady) begin
                    pc_d    = (advance && ifNop) ? redir : pend_pc;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            IFIDInst  <= '0;
            IFIDPC4   <= '0;
            IFIDValid <= 1'b0;
            hold_inst <= '0;
            hold_pc4  <= '0;
            pend_pc   <= '0;
            stallCnt  <= '0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            IFIDInst  <= inst_d;
            IFIDPC4   <= pc4_d;
            IFIDValid <= valid_d;
            hold_inst <= hold_inst_d;
            hold_pc4  <= hold_pc4_d;
            pend_pc   <= pend_pc_d;
            if (fetchStall && stallCnt != 16'hFFFF)
                stallCnt <= stallCnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage with a word-per-address memory model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pcWrite = 1'b1;
    logic        IFIDWrite = 1'b1;
    logic        ifNop = 1'b0;
    logic [31:0] redirectPC = '0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic        imemReady = 1'b1;
    logic [31:0] IFIDInst;
    logic [31:0] IFIDPC4;
    logic        IFIDValid;
    logic        fetchStall;
    logic [15:0] stallCnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } exp_t;
    exp_t q[$];
    logic adv_prev = 1'b0;

    if_stage dut (
        .clk(clk), .rst(rst), .pcWrite(pcWrite), .IFIDWrite(IFIDWrite),
        .ifNop(ifNop), .redirectPC(redirectPC), .imemReq(imemReq),
        .imemAddr(imemAddr), .imemRdata(imemRdata), .imemReady(imemReady),
        .IFIDInst(IFIDInst), .IFIDPC4(IFIDPC4), .IFIDValid(IFIDValid),
        .fetchStall(fetchStall), .stallCnt(stallCnt)
    );

    always #5 clk = ~clk;

    // Memory returns a word tagged with its own address.
    assign imemRdata = 32'hC000_0000 | imemAddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc4);
        exp_t e;
        e.inst = inst;
        e.pc4  = pc4;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) adv_prev <= rst & IFIDWrite & pcWrite;

    always @(negedge clk) begin
        if (rst && adv_prev) begin
            if (IFIDValid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid_pc4", IFIDPC4, 32'hxxxx_xxxx);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("ifid_inst", IFIDInst, e.inst);
                    chk("ifid_pc4", IFIDPC4, e.pc4);
                end
            end else begin
                chk("bubble_inst", IFIDInst, 32'h0);
            end
        end
    end

    initial begin
        #2;
        chk("rst_inst", IFIDInst, 32'h0);
        chk("rst_pc4", IFIDPC4, 32'h0);
        chk("rst_valid", {31'b0, IFIDValid}, 32'h0);
        chk("rst_stallcnt", {16'b0, stallCnt}, 32'h0);
        chk("rst_addr", imemAddr, 32'h0);
        step();
        rst = 1'b1;
        #1;
        chk("first_req", {31'b0, imemReq}, 32'h1);
        chk("first_addr", imemAddr, 32'h0);
        // zero-wait stream
        push(32'hC000_0000, 32'd4);
        push(32'hC000_0004, 32'd8);
        step();
        step();
        // wait states at PC=8
        imemReady = 1'b0;
        #1;
        chk("zw_stallcnt", {16'b0, stallCnt}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("ws_stall", {31'b0, fetchStall}, 32'h1);
            chk("ws_addr", imemAddr, 32'd8);
            step();
        end
        imemReady = 1'b1;
        #1;
        chk("ws_stallcnt", {16'b0, stallCnt}, 32'd3);
        chk("ws_addr_after", imemAddr, 32'd8);
        push(32'hC000_0008, 32'd12);
        push(32'hC000_000C, 32'd16);
        step();
        step();
        // stall during response at PC=16
        pcWrite = 1'b0;
        step();
        chk("hold_req", {31'b0, imemReq}, 32'h0);
        chk("hold_pc4", IFIDPC4, 32'd16);
        chk("hold_valid", {31'b0, IFIDValid}, 32'h1);
        step();
        chk("hold_inst", IFIDInst, 32'hC000_000C);
        pcWrite = 1'b1;
        push(32'hC000_0010, 32'd20);
        step();
        chk("hold_next_addr", imemAddr, 32'd20);
        push(32'hC000_0014, 32'd24);
        step();
        // redirect in flight at PC=24
        imemReady = 1'b0;
        ifNop = 1'b1;
        redirectPC = 32'h0000_0103;
        step();
        ifNop = 1'b0;
        #1;
        chk("drop_addr", imemAddr, 32'd24);
        chk("drop_req", {31'b0, imemReq}, 32'h1);
        step();
        imemReady = 1'b1;
        #1;
        chk("drop_stall_ready", {31'b0, fetchStall}, 32'h1);
        step();
        chk("redir_addr", imemAddr, 32'h100);
        chk("redir_stallcnt", {16'b0, stallCnt}, 32'd6);
        push(32'hC000_0100, 32'h104);
        step();
        // stall priority: redirect ignored while advance=0
        IFIDWrite = 1'b0;
        ifNop = 1'b1;
        redirectPC = 32'h200;
        step();
        chk("prio_pc4", IFIDPC4, 32'h104);
        chk("prio_inst", IFIDInst, 32'hC000_0100);
        chk("prio_addr", imemAddr, 32'h104);
        step();
        IFIDWrite = 1'b1;
        ifNop = 1'b0;
        push(32'hC000_0104, 32'h108);
        step();
        chk("prio_next_addr", imemAddr, 32'h108);
        // asynchronous reset in the middle of DROP
        imemReady = 1'b0;
        ifNop = 1'b1;
        redirectPC = 32'h300;
        step();
        ifNop = 1'b0;
        #1;
        chk("pre_rst_drop_stall", {31'b0, fetchStall}, 32'h1);
        chk("pre_rst_drop_addr", imemAddr, 32'h108);
        #1;
        rst = 1'b0;
        imemReady = 1'b1;
        #1;
        chk("arst_inst", IFIDInst, 32'h0);
        chk("arst_pc4", IFIDPC4, 32'h0);
        chk("arst_valid", {31'b0, IFIDValid}, 32'h0);
        chk("arst_stallcnt", {16'b0, stallCnt}, 32'h0);
        chk("arst_addr", imemAddr, 32'h0);
        chk("arst_stall", {31'b0, fetchStall}, 32'h0);
        step();
        rst = 1'b1;
        #1;
        chk("rerun_addr", imemAddr, 32'h0);
        push(32'hC000_0000, 32'd4);
        step();
        // saturation of the stall counter
        imemReady = 1'b0;
        repeat (65540) step();
        chk("sat_stallcnt", {16'b0, stallCnt}, 32'h0000_FFFF);
        step();
        chk("sat_hold", {16'b0, stallCnt}, 32'h0000_FFFF);
        chk("queue_empty", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
